// File: rtl/axi_arb_pkg.sv
// Shared FSM state encodings, AXI constants and the round-robin pointer helper
// for the AXI master arbiter.
package axi_arb_pkg;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_ADDR = 2'd1,
    RD_DATA = 2'd2
  } rd_state_e;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_ADDR = 2'd1,
    WR_DATA = 2'd2,
    WR_RESP = 2'd3
  } wr_state_e;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  // Pointer moves to the client just after the one that finished, wrapping at n.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: lowest requesting index at or after ptr wins.
// Zero latency; returns a one-hot grant, its index and a valid flag.
module rr_arbiter #(
  parameter int N    = 3,
  parameter int IDXW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [IDXW-1:0] gnt_idx,
  output logic            gnt_vld
);

  int cand;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    cand    = 0;
    for (int i = 0; i < N; i++) begin
      cand = int'(ptr) + i;
      if (cand >= N) cand = cand - N;
      for (int j = 0; j < N; j++) begin
        if (j == cand && req[j] && !gnt_vld) begin
          gnt_vld = 1'b1;
          gnt[j]  = 1'b1;
          gnt_idx = IDXW'(j);
        end
      end
    end
  end

endmodule

// File: rtl/axi_master_arbiter.sv
// N clients onto one AXI3 master: independent read/write FSMs, one burst per direction; AXI_ARB_PERF_EN adds beat/stall counters.
// Grant in the request cycle, ar/awvalid one cycle later; AXI and client stalls pass straight through while a burst is active.
module axi_master_arbiter
  import axi_arb_pkg::*;
#(
  parameter int N_CLIENTS  = 3,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [N_CLIENTS-1:0]              c_ar_valid,
  output logic [N_CLIENTS-1:0]              c_ar_ready,
  input  logic [N_CLIENTS*ADDR_WIDTH-1:0]   c_ar_addr,
  input  logic [N_CLIENTS*8-1:0]            c_ar_len,
  input  logic [N_CLIENTS*3-1:0]            c_ar_size,
  output logic [N_CLIENTS-1:0]              c_r_valid,
  output logic [DATA_WIDTH-1:0]             c_r_data,
  output logic [1:0]                        c_r_resp,
  output logic                              c_r_last,
  input  logic [N_CLIENTS-1:0]              c_aw_valid,
  output logic [N_CLIENTS-1:0]              c_aw_ready,
  input  logic [N_CLIENTS*ADDR_WIDTH-1:0]   c_aw_addr,
  input  logic [N_CLIENTS*8-1:0]            c_aw_len,
  input  logic [N_CLIENTS*3-1:0]            c_aw_size,
  input  logic [N_CLIENTS-1:0]              c_w_valid,
  input  logic [N_CLIENTS-1:0]              c_w_last,
  output logic [N_CLIENTS-1:0]              c_w_ready,
  input  logic [N_CLIENTS*DATA_WIDTH-1:0]   c_w_data,
  input  logic [N_CLIENTS*DATA_WIDTH/8-1:0] c_w_strb,
  output logic [N_CLIENTS-1:0]              c_b_valid,
  output logic [1:0]                        c_b_resp,
  output logic [ID_WIDTH-1:0]               arid,
  output logic [ADDR_WIDTH-1:0]             araddr,
  output logic [7:0]                        arlen,
  output logic [2:0]                        arsize,
  output logic [1:0]                        arburst,
  output logic [1:0]                        arlock,
  output logic [3:0]                        arcache,
  output logic [2:0]                        arprot,
  output logic                              arvalid,
  input  logic                              arready,
  input  logic [ID_WIDTH-1:0]               rid,
  input  logic [DATA_WIDTH-1:0]             rdata,
  input  logic [1:0]                        rresp,
  input  logic                              rlast,
  input  logic                              rvalid,
  output logic                              rready,
  output logic [ID_WIDTH-1:0]               awid,
  output logic [ADDR_WIDTH-1:0]             awaddr,
  output logic [7:0]                        awlen,
  output logic [2:0]                        awsize,
  output logic [1:0]                        awburst,
  output logic [1:0]                        awlock,
  output logic [3:0]                        awcache,
  output logic [2:0]                        awprot,
  output logic                              awvalid,
  input  logic                              awready,
  output logic [ID_WIDTH-1:0]               wid,
  output logic [DATA_WIDTH-1:0]             wdata,
  output logic [DATA_WIDTH/8-1:0]           wstrb,
  output logic                              wlast,
  output logic                              wvalid,
  input  logic                              wready,
  input  logic [ID_WIDTH-1:0]               bid,
  input  logic [1:0]                        bresp,
  input  logic                              bvalid,
  output logic                              bready
`ifdef AXI_ARB_PERF_EN
  ,
  output logic [31:0]                       perf_rd_beats,
  output logic [31:0]                       perf_wr_beats,
  output logic [31:0]                       perf_stall
`endif
);

  localparam int IDXW   = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
  localparam int STRB_W = DATA_WIDTH / 8;

  rd_state_e rd_state_q, rd_state_d;
  wr_state_e wr_state_q, wr_state_d;
  logic [IDXW-1:0] rd_gnt_q, rd_gnt_d, rd_ptr_q, rd_ptr_d;
  logic [IDXW-1:0] wr_gnt_q, wr_gnt_d, wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d, aw_addr_q, aw_addr_d;
  logic [7:0] ar_len_q, ar_len_d, aw_len_q, aw_len_d;
  logic [2:0] ar_size_q, ar_size_d, aw_size_q, aw_size_d;

  logic [N_CLIENTS-1:0] rd_gnt_oh, wr_gnt_oh;
  logic [IDXW-1:0]      rd_gnt_idx, wr_gnt_idx;
  logic                 rd_gnt_vld, wr_gnt_vld;
  logic                 rd_data_st, wr_data_st, wr_resp_st;

  // Responses are matched by the single-outstanding rule, so the ids are not inspected.
  logic unused_ids;
  assign unused_ids = ^{rid, bid};

  rr_arbiter #(.N(N_CLIENTS), .IDXW(IDXW)) u_rd_arb (
    .req(c_ar_valid), .ptr(rd_ptr_q), .gnt(rd_gnt_oh), .gnt_idx(rd_gnt_idx), .gnt_vld(rd_gnt_vld)
  );

  rr_arbiter #(.N(N_CLIENTS), .IDXW(IDXW)) u_wr_arb (
    .req(c_aw_valid), .ptr(wr_ptr_q), .gnt(wr_gnt_oh), .gnt_idx(wr_gnt_idx), .gnt_vld(wr_gnt_vld)
  );

  always_comb begin
    rd_state_d = rd_state_q;
    rd_gnt_d   = rd_gnt_q;
    rd_ptr_d   = rd_ptr_q;
    ar_addr_d  = ar_addr_q;
    ar_len_d   = ar_len_q;
    ar_size_d  = ar_size_q;
    c_ar_ready = '0;
    unique case (rd_state_q)
      RD_IDLE: if (rd_gnt_vld) begin
        c_ar_ready = rd_gnt_oh;
        rd_gnt_d   = rd_gnt_idx;
        ar_addr_d  = c_ar_addr[int'(rd_gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        ar_len_d   = c_ar_len[int'(rd_gnt_idx)*8 +: 8];
        ar_size_d  = c_ar_size[int'(rd_gnt_idx)*3 +: 3];
        rd_state_d = RD_ADDR;
      end
      RD_ADDR: if (arready) rd_state_d = RD_DATA;
      RD_DATA: if (rvalid && rlast) begin
        rd_state_d = RD_IDLE;
        rd_ptr_d   = IDXW'(rr_next(int'(rd_gnt_q), N_CLIENTS));
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_comb begin
    wr_state_d = wr_state_q;
    wr_gnt_d   = wr_gnt_q;
    wr_ptr_d   = wr_ptr_q;
    aw_addr_d  = aw_addr_q;
    aw_len_d   = aw_len_q;
    aw_size_d  = aw_size_q;
    c_aw_ready = '0;
    unique case (wr_state_q)
      WR_IDLE: if (wr_gnt_vld) begin
        c_aw_ready = wr_gnt_oh;
        wr_gnt_d   = wr_gnt_idx;
        aw_addr_d  = c_aw_addr[int'(wr_gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        aw_len_d   = c_aw_len[int'(wr_gnt_idx)*8 +: 8];
        aw_size_d  = c_aw_size[int'(wr_gnt_idx)*3 +: 3];
        wr_state_d = WR_ADDR;
      end
      WR_ADDR: if (awready) wr_state_d = WR_DATA;
      WR_DATA: if (wvalid && wready && wlast) wr_state_d = WR_RESP;
      WR_RESP: if (bvalid) begin
        wr_state_d = WR_IDLE;
        wr_ptr_d   = IDXW'(rr_next(int'(wr_gnt_q), N_CLIENTS));
      end
      default: wr_state_d = WR_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_state_q <= RD_IDLE;
      wr_state_q <= WR_IDLE;
      rd_gnt_q   <= '0;
      rd_ptr_q   <= '0;
      wr_gnt_q   <= '0;
      wr_ptr_q   <= '0;
      ar_addr_q  <= '0;
      ar_len_q   <= '0;
      ar_size_q  <= '0;
      aw_addr_q  <= '0;
      aw_len_q   <= '0;
      aw_size_q  <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      wr_state_q <= wr_state_d;
      rd_gnt_q   <= rd_gnt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_gnt_q   <= wr_gnt_d;
      wr_ptr_q   <= wr_ptr_d;
      ar_addr_q  <= ar_addr_d;
      ar_len_q   <= ar_len_d;
      ar_size_q  <= ar_size_d;
      aw_addr_q  <= aw_addr_d;
      aw_len_q   <= aw_len_d;
      aw_size_q  <= aw_size_d;
    end
  end

  assign rd_data_st = (rd_state_q == RD_DATA);
  assign wr_data_st = (wr_state_q == WR_DATA);
  assign wr_resp_st = (wr_state_q == WR_RESP);

  assign arid    = ID_WIDTH'(rd_gnt_q);
  assign araddr  = ar_addr_q;
  assign arlen   = ar_len_q;
  assign arsize  = ar_size_q;
  assign arburst = AXI_BURST_INCR;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;
  assign arvalid = (rd_state_q == RD_ADDR);
  assign rready  = rd_data_st;

  assign awid    = ID_WIDTH'(wr_gnt_q);
  assign awaddr  = aw_addr_q;
  assign awlen   = aw_len_q;
  assign awsize  = aw_size_q;
  assign awburst = AXI_BURST_INCR;
  assign awlock  = 2'b00;
  assign awcache = 4'b0000;
  assign awprot  = 3'b000;
  assign awvalid = (wr_state_q == WR_ADDR);
  assign bready  = wr_resp_st;

  assign wid    = ID_WIDTH'(wr_gnt_q);
  assign wvalid = wr_data_st && c_w_valid[wr_gnt_q];
  assign wlast  = wr_data_st && c_w_last[wr_gnt_q];
  assign wdata  = wr_data_st ? c_w_data[int'(wr_gnt_q)*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign wstrb  = wr_data_st ? c_w_strb[int'(wr_gnt_q)*STRB_W +: STRB_W] : '0;

  assign c_r_data = rd_data_st ? rdata : '0;
  assign c_r_resp = rd_data_st ? rresp : AXI_RESP_OKAY;
  assign c_r_last = rd_data_st && rlast;
  assign c_b_resp = (wr_resp_st && bvalid) ? bresp : AXI_RESP_OKAY;

  always_comb begin
    c_r_valid = '0;
    c_w_ready = '0;
    c_b_valid = '0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      c_r_valid[i] = rd_data_st && rvalid && (rd_gnt_q == IDXW'(i));
      c_w_ready[i] = wr_data_st && wready && (wr_gnt_q == IDXW'(i));
      c_b_valid[i] = wr_resp_st && bvalid && (wr_gnt_q == IDXW'(i));
    end
  end

`ifdef AXI_ARB_PERF_EN
  logic [31:0] perf_rd_beats_q, perf_rd_beats_d;
  logic [31:0] perf_wr_beats_q, perf_wr_beats_d;
  logic [31:0] perf_stall_q, perf_stall_d;
  logic        stall_now;

  // A stall cycle is any cycle where some client holds a request that is not being granted.
  assign stall_now = (|(c_ar_valid & ~c_ar_ready)) || (|(c_aw_valid & ~c_aw_ready));

  always_comb begin
    perf_rd_beats_d = perf_rd_beats_q + ((rvalid && rready) ? 32'd1 : 32'd0);
    perf_wr_beats_d = perf_wr_beats_q + ((wvalid && wready) ? 32'd1 : 32'd0);
    perf_stall_d    = perf_stall_q + (stall_now ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_rd_beats_q <= '0;
      perf_wr_beats_q <= '0;
      perf_stall_q    <= '0;
    end else begin
      perf_rd_beats_q <= perf_rd_beats_d;
      perf_wr_beats_q <= perf_wr_beats_d;
      perf_stall_q    <= perf_stall_d;
    end
  end

  assign perf_rd_beats = perf_rd_beats_q;
  assign perf_wr_beats = perf_wr_beats_q;
  assign perf_stall    = perf_stall_q;
`endif

endmodule

// File: tb/tb_axi_master_arbiter.sv
// Directed bench for axi_master_arbiter: the bench plays both the clients and the AXI slave.
module tb_axi_master_arbiter;
  import axi_arb_pkg::*;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 4;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic [N-1:0]      c_ar_valid, c_ar_ready, c_r_valid;
  logic [N*AW-1:0]   c_ar_addr, c_aw_addr;
  logic [N*8-1:0]    c_ar_len, c_aw_len;
  logic [N*3-1:0]    c_ar_size, c_aw_size;
  logic [DW-1:0]     c_r_data;
  logic [1:0]        c_r_resp, c_b_resp;
  logic              c_r_last;
  logic [N-1:0]      c_aw_valid, c_aw_ready, c_w_valid, c_w_last, c_w_ready, c_b_valid;
  logic [N*DW-1:0]   c_w_data;
  logic [N*DW/8-1:0] c_w_strb;
  logic [IW-1:0]     arid, awid, wid, rid, bid;
  logic [AW-1:0]     araddr, awaddr;
  logic [7:0]        arlen, awlen;
  logic [2:0]        arsize, awsize, arprot, awprot;
  logic [1:0]        arburst, awburst, arlock, awlock, rresp, bresp;
  logic [3:0]        arcache, awcache;
  logic              arvalid, arready, rlast, rvalid, rready;
  logic              awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [DW-1:0]     rdata, wdata;
  logic [DW/8-1:0]   wstrb;
`ifdef AXI_ARB_PERF_EN
  logic [31:0]       perf_rd_beats, perf_wr_beats, perf_stall;
`endif

  int n_cmp = 0;
  int n_err = 0;

  axi_master_arbiter #(.N_CLIENTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .clock(clock), .reset(reset),
    .c_ar_valid(c_ar_valid), .c_ar_ready(c_ar_ready), .c_ar_addr(c_ar_addr),
    .c_ar_len(c_ar_len), .c_ar_size(c_ar_size),
    .c_r_valid(c_r_valid), .c_r_data(c_r_data), .c_r_resp(c_r_resp), .c_r_last(c_r_last),
    .c_aw_valid(c_aw_valid), .c_aw_ready(c_aw_ready), .c_aw_addr(c_aw_addr),
    .c_aw_len(c_aw_len), .c_aw_size(c_aw_size),
    .c_w_valid(c_w_valid), .c_w_last(c_w_last), .c_w_ready(c_w_ready),
    .c_w_data(c_w_data), .c_w_strb(c_w_strb),
    .c_b_valid(c_b_valid), .c_b_resp(c_b_resp),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
`ifdef AXI_ARB_PERF_EN
    , .perf_rd_beats(perf_rd_beats), .perf_wr_beats(perf_wr_beats), .perf_stall(perf_stall)
`endif
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    c_ar_valid = '0; c_ar_addr = '0; c_ar_len = '0; c_ar_size = '0;
    c_aw_valid = '0; c_aw_addr = '0; c_aw_len = '0; c_aw_size = '0;
    c_w_valid = '0; c_w_last = '0; c_w_data = '0; c_w_strb = '0;
    arready = 1'b0; rid = '0; rdata = '0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bid = '0; bresp = 2'b00; bvalid = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // Slave side of a single-beat read, started with the arbiter in RD_ADDR.
  task automatic finish_rd_single();
    arready = 1'b1;
    step();
    arready = 1'b0;
    rvalid = 1'b1; rlast = 1'b1; rdata = 32'hDEAD_0000;
    step();
    rvalid = 1'b0; rlast = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++;
    if ({arvalid, awvalid, wvalid, rready, bready} !== 5'b0) begin
      n_err++; $display("FAIL reset_valids: got %b want 00000", {arvalid, awvalid, wvalid, rready, bready});
    end
    n_cmp++;
    if ({c_ar_ready, c_aw_ready, c_w_ready, c_r_valid, c_b_valid} !== 15'b0) begin
      n_err++; $display("FAIL reset_client_hs: got %h want 0", {c_ar_ready, c_aw_ready, c_w_ready, c_r_valid, c_b_valid});
    end
    n_cmp++;
    if (araddr !== 32'h0 || awaddr !== 32'h0 || arid !== 4'h0 || arlen !== 8'h0 || wdata !== 32'h0) begin
      n_err++; $display("FAIL reset_payload: araddr=%h awaddr=%h arid=%h arlen=%h wdata=%h want all 0", araddr, awaddr, arid, arlen, wdata);
    end
    n_cmp++;
    if (arburst !== 2'b01 || arlock !== 2'b00 || arcache !== 4'h0 || arprot !== 3'h0) begin
      n_err++; $display("FAIL reset_consts: burst=%b lock=%b cache=%h prot=%h want 01/00/0/0", arburst, arlock, arcache, arprot);
    end
  endtask

  task automatic test_read_single();
    c_ar_valid = 3'b010;
    c_ar_addr  = {32'h0, 32'h1C00_0000, 32'h0};
    c_ar_len   = {8'd0, 8'd3, 8'd0};
    c_ar_size  = {3'd0, 3'd2, 3'd0};
    #1;
    n_cmp++;
    if (c_ar_ready !== 3'b010) begin
      n_err++; $display("FAIL rd1_grant: c_ar_ready=%b want 010", c_ar_ready);
    end
    step();
    c_ar_valid = '0;
    #1;
    n_cmp++;
    if (arvalid !== 1'b1 || arid !== 4'd1 || araddr !== 32'h1C00_0000 || arlen !== 8'd3 || arsize !== 3'd2) begin
      n_err++; $display("FAIL rd1_ar: valid=%b id=%h addr=%h len=%h size=%h want 1/1/1c000000/3/2", arvalid, arid, araddr, arlen, arsize);
    end
    arready = 1'b1;
    step();
    arready = 1'b0;
    #1;
    n_cmp++;
    if (rready !== 1'b1 || arvalid !== 1'b0) begin
      n_err++; $display("FAIL rd1_data_phase: rready=%b arvalid=%b want 1/0", rready, arvalid);
    end
    for (int i = 0; i < 4; i++) begin
      rvalid = 1'b1; rresp = 2'b00; rlast = (i == 3); rdata = DW'(32'hA0 + i);
      #1;
      n_cmp++;
      if (c_r_valid !== 3'b010 || c_r_data !== DW'(32'hA0 + i) || c_r_last !== (i == 3)) begin
        n_err++; $display("FAIL rd1_beat%0d: c_r_valid=%b data=%h last=%b want 010/%h/%b", i, c_r_valid, c_r_data, c_r_last, 32'hA0 + i, i == 3);
      end
      step();
    end
    rvalid = 1'b0; rlast = 1'b0;
    #1;
    n_cmp++;
    if (rready !== 1'b0 || c_r_valid !== 3'b000) begin
      n_err++; $display("FAIL rd1_idle: rready=%b c_r_valid=%b want 0/000", rready, c_r_valid);
    end
`ifdef AXI_ARB_PERF_EN
    n_cmp++;
    if (perf_rd_beats !== 32'd4) begin
      n_err++; $display("FAIL perf_rd_beats: got %0d want 4", perf_rd_beats);
    end
`endif
  endtask

  task automatic test_round_robin();
    int exp_order[4] = '{0, 1, 2, 0};
    logic [N-1:0] exp_oh;
    do_reset();
    c_ar_valid = 3'b111;
    for (int k = 0; k < 4; k++) begin
      exp_oh = 3'b001 << exp_order[k];
      #1;
      n_cmp++;
      if (c_ar_ready !== exp_oh) begin
        n_err++; $display("FAIL rr_grant%0d: c_ar_ready=%b want %b", k, c_ar_ready, exp_oh);
      end
      step();
      #1;
      n_cmp++;
      if (arid !== IW'(exp_order[k]) || c_ar_ready !== 3'b000) begin
        n_err++; $display("FAIL rr_arid%0d: arid=%0d c_ar_ready=%b want %0d/000", k, arid, c_ar_ready, exp_order[k]);
      end
      finish_rd_single();
    end
    // Pointer now sits at 1: client 2 is the first requester at or after it.
    c_ar_valid = 3'b101;
    #1;
    n_cmp++;
    if (c_ar_ready !== 3'b100) begin
      n_err++; $display("FAIL rr_skip: c_ar_ready=%b want 100", c_ar_ready);
    end
    step();
    c_ar_valid = '0;
    finish_rd_single();
    c_ar_valid = 3'b110;
    #1;
    n_cmp++;
    if (c_ar_ready !== 3'b010) begin
      n_err++; $display("FAIL rr_wrap: c_ar_ready=%b want 010", c_ar_ready);
    end
    step();
    c_ar_valid = '0;
    finish_rd_single();
  endtask

  task automatic test_write();
    c_aw_valid = 3'b100;
    c_aw_addr  = {32'h1D00_0040, 32'h0, 32'h0};
    c_aw_len   = {8'd1, 8'd0, 8'd0};
    c_aw_size  = {3'd2, 3'd0, 3'd0};
    #1;
    n_cmp++;
    if (c_aw_ready !== 3'b100) begin
      n_err++; $display("FAIL wr_grant: c_aw_ready=%b want 100", c_aw_ready);
    end
    step();
    c_aw_valid = '0;
    #1;
    n_cmp++;
    if (awvalid !== 1'b1 || awid !== 4'd2 || awaddr !== 32'h1D00_0040 || awlen !== 8'd1 || awburst !== 2'b01) begin
      n_err++; $display("FAIL wr_aw: valid=%b id=%h addr=%h len=%h burst=%b want 1/2/1d000040/1/01", awvalid, awid, awaddr, awlen, awburst);
    end
    awready = 1'b1;
    step();
    awready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      c_w_valid = 3'b100;
      c_w_last  = (i == 1) ? 3'b100 : 3'b000;
      c_w_data  = {DW'(32'hC0DE_0000 + i), 32'h0, 32'h0};
      c_w_strb  = {4'hF, 4'h0, 4'h0};
      wready    = 1'b1;
      #1;
      n_cmp++;
      if (wvalid !== 1'b1 || wid !== 4'd2 || wdata !== DW'(32'hC0DE_0000 + i) || wstrb !== 4'hF ||
          wlast !== (i == 1) || c_w_ready !== 3'b100) begin
        n_err++; $display("FAIL wr_beat%0d: wvalid=%b wid=%h wdata=%h wstrb=%h wlast=%b c_w_ready=%b want 1/2/%h/f/%b/100",
                          i, wvalid, wid, wdata, wstrb, wlast, c_w_ready, 32'hC0DE_0000 + i, i == 1);
      end
      step();
    end
    c_w_valid = '0; c_w_last = '0; wready = 1'b0;
    #1;
    n_cmp++;
    if (bready !== 1'b1 || wvalid !== 1'b0 || c_b_valid !== 3'b000) begin
      n_err++; $display("FAIL wr_resp_wait: bready=%b wvalid=%b c_b_valid=%b want 1/0/000", bready, wvalid, c_b_valid);
    end
    bvalid = 1'b1; bresp = AXI_RESP_OKAY;
    #1;
    n_cmp++;
    if (c_b_valid !== 3'b100 || c_b_resp !== 2'b00) begin
      n_err++; $display("FAIL wr_b_pulse: c_b_valid=%b c_b_resp=%b want 100/00", c_b_valid, c_b_resp);
    end
    step();
    #1;
    n_cmp++;
    if (c_b_valid !== 3'b000 || bready !== 1'b0) begin
      n_err++; $display("FAIL wr_b_once: c_b_valid=%b bready=%b want 000/0", c_b_valid, bready);
    end
    bvalid = 1'b0;
  endtask

  task automatic test_bresp_err();
    c_aw_valid = 3'b001;
    c_aw_addr  = {32'h0, 32'h0, 32'h1E00_0000};
    c_aw_len   = '0;
    step();
    c_aw_valid = '0;
    awready = 1'b1;
    step();
    awready = 1'b0;
    c_w_valid = 3'b001; c_w_last = 3'b001; c_w_data = {64'h0, 32'h1234_5678}; c_w_strb = 12'h00F;
    wready = 1'b1;
    step();
    c_w_valid = '0; c_w_last = '0; wready = 1'b0;
    bvalid = 1'b1; bresp = AXI_RESP_SLVERR;
    #1;
    n_cmp++;
    if (c_b_valid !== 3'b001 || c_b_resp !== 2'b10) begin
      n_err++; $display("FAIL bresp_err: c_b_valid=%b c_b_resp=%b want 001/10", c_b_valid, c_b_resp);
    end
    step();
    bvalid = 1'b0; bresp = 2'b00;
  endtask

  task automatic test_concurrent_stalls();
    bit ar_g = 0, aw_g = 0, ar_acc = 0, aw_acc = 0;
    bit r_done = 0, w_done = 0, b_done = 0;
    int rb = 0, wb = 0;
    c_ar_addr = {32'h0, 32'h0, 32'h2000_0000};
    c_ar_len  = {8'd0, 8'd0, 8'd3};
    c_aw_addr = {32'h0, 32'h3000_0000, 32'h0};
    c_aw_len  = {8'd0, 8'd3, 8'd0};
    c_w_strb  = {4'h0, 4'hF, 4'h0};
    for (int cyc = 0; cyc < 400 && !(r_done && b_done); cyc++) begin
      c_ar_valid = ar_g ? 3'b000 : 3'b001;
      c_aw_valid = aw_g ? 3'b000 : 3'b010;
      arready    = 1'($urandom_range(0, 1));
      awready    = 1'($urandom_range(0, 1));
      rvalid     = ar_acc && !r_done && 1'($urandom_range(0, 1));
      rdata      = DW'(32'h500 + rb);
      rlast      = (rb == 3);
      c_w_valid  = (aw_acc && !w_done && 1'($urandom_range(0, 1))) ? 3'b010 : 3'b000;
      c_w_data   = {32'h0, DW'(32'h700 + wb), 32'h0};
      c_w_last   = (wb == 3) ? 3'b010 : 3'b000;
      wready     = 1'($urandom_range(0, 1));
      bvalid     = w_done && !b_done && 1'($urandom_range(0, 1));
      bresp      = 2'b00;
      #1;
      if (c_ar_ready[0]) ar_g = 1;
      if (c_aw_ready[1]) aw_g = 1;
      if (arvalid) begin
        n_cmp++;
        if (araddr !== 32'h2000_0000 || arid !== 4'd0 || arlen !== 8'd3) begin
          n_err++; $display("FAIL cc_ar_stable: addr=%h id=%h len=%h want 20000000/0/3", araddr, arid, arlen);
        end
        if (arready) ar_acc = 1;
      end
      if (awvalid) begin
        n_cmp++;
        if (awaddr !== 32'h3000_0000 || awid !== 4'd1 || awlen !== 8'd3) begin
          n_err++; $display("FAIL cc_aw_stable: addr=%h id=%h len=%h want 30000000/1/3", awaddr, awid, awlen);
        end
        if (awready) aw_acc = 1;
      end
      if (rvalid && rready) begin
        n_cmp++;
        if (c_r_valid !== 3'b001 || c_r_data !== DW'(32'h500 + rb)) begin
          n_err++; $display("FAIL cc_r_beat%0d: c_r_valid=%b data=%h want 001/%h", rb, c_r_valid, c_r_data, 32'h500 + rb);
        end
        if (rlast) r_done = 1;
        rb++;
      end
      if (wvalid) begin
        n_cmp++;
        if (wdata !== DW'(32'h700 + wb) || wid !== 4'd1 || wlast !== (wb == 3)) begin
          n_err++; $display("FAIL cc_w_beat%0d: wdata=%h wid=%h wlast=%b want %h/1/%b", wb, wdata, wid, wlast, 32'h700 + wb, wb == 3);
        end
        if (wready) begin
          if (wb == 3) w_done = 1;
          wb++;
        end
      end
      if (bvalid && bready) begin
        n_cmp++;
        if (c_b_valid !== 3'b010) begin
          n_err++; $display("FAIL cc_b: c_b_valid=%b want 010", c_b_valid);
        end
        b_done = 1;
      end
      step();
    end
    clear_inputs();
    n_cmp++;
    if (!(r_done && b_done) || rb != 4 || wb != 4) begin
      n_err++; $display("FAIL cc_complete: r_done=%0d b_done=%0d rbeats=%0d wbeats=%0d want 1/1/4/4", r_done, b_done, rb, wb);
    end
  endtask

  task automatic test_reset_mid_burst();
    c_ar_valid = 3'b001;
    c_ar_addr  = {32'h0, 32'h0, 32'h4000_0000};
    c_ar_len   = {8'd0, 8'd0, 8'd3};
    step();
    c_ar_valid = '0;
    arready = 1'b1;
    step();
    arready = 1'b0;
    rvalid = 1'b1; rdata = 32'h1; rlast = 1'b0;
    step();
    rdata = 32'h2;
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    n_cmp++;
    if (arvalid !== 1'b0 || rready !== 1'b0 || c_r_valid !== 3'b000 || araddr !== 32'h0) begin
      n_err++; $display("FAIL rst_mid: arvalid=%b rready=%b c_r_valid=%b araddr=%h want 0/0/000/0", arvalid, rready, c_r_valid, araddr);
    end
`ifdef AXI_ARB_PERF_EN
    n_cmp++;
    if (perf_rd_beats !== 32'd0) begin
      n_err++; $display("FAIL perf_clear: perf_rd_beats=%0d want 0", perf_rd_beats);
    end
`endif
    rvalid = 1'b0;
    c_ar_valid = 3'b010;
    c_ar_addr  = {32'h0, 32'h5000_0000, 32'h0};
    c_ar_len   = '0;
    #1;
    n_cmp++;
    if (c_ar_ready !== 3'b010) begin
      n_err++; $display("FAIL rst_regrant: c_ar_ready=%b want 010", c_ar_ready);
    end
    step();
    c_ar_valid = '0;
    #1;
    n_cmp++;
    if (arvalid !== 1'b1 || arid !== 4'd1 || araddr !== 32'h5000_0000) begin
      n_err++; $display("FAIL rst_new_ar: arvalid=%b arid=%h araddr=%h want 1/1/50000000", arvalid, arid, araddr);
    end
    arready = 1'b1;
    step();
    arready = 1'b0;
    rvalid = 1'b1; rlast = 1'b1; rdata = 32'hBEEF;
    #1;
    n_cmp++;
    if (c_r_valid !== 3'b010 || c_r_data !== 32'hBEEF) begin
      n_err++; $display("FAIL rst_new_r: c_r_valid=%b data=%h want 010/0000beef", c_r_valid, c_r_data);
    end
    step();
    rvalid = 1'b0; rlast = 1'b0;
    #1;
    n_cmp++;
    if (rready !== 1'b0) begin
      n_err++; $display("FAIL rst_new_done: rready=%b want 0", rready);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_read_single();
    test_round_robin();
    test_write();
    test_bresp_err();
    test_concurrent_stalls();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
